// File: rtl/i2s_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stream_mux
// Purpose  : Per-channel frame-commit FIFOs feeding a round-robin frame
//            arbiter; overflowing frames are dropped whole. Defining
//            I2S_STREAM_MUX_HDR_EN adds one channel-index header beat per frame.
// Revision : 1.0
// ============================================================================
module i2s_stream_mux #(
  parameter  int CN         = 16,
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 128,
  localparam int CW         = $clog2(CN)
) (
  input  logic                     sys_clk,
  input  logic                     arst_n,
  input  logic [CN-1:0]            s_axis_tvalid,
  input  logic [DATA_WIDTH*CN-1:0] s_axis_tdata,
  input  logic [CN-1:0]            s_axis_tlast,
  output logic [CN-1:0]            s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [CW-1:0]            m_axis_tid,
  input  logic                     m_axis_tready,
  input  logic [CN-1:0]            i_enable,
  output logic [16*CN-1:0]         o_frame_count,
  output logic [16*CN-1:0]         o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef I2S_STREAM_MUX_HDR_EN
    HDR  = 2'd1,
`endif
    DATA = 2'd2
  } state_t;

  logic                in_ready;
  logic [CN-1:0]       avail;
  logic [CN-1:0]       pop;
  logic [DATA_WIDTH:0] rd_word [CN];
  logic [15:0]         frame_cnt [CN];

  state_t              state;
  logic [CW-1:0]       grant;
  logic [CW-1:0]       last_grant;
  logic [CW-1:0]       next_grant;
  logic                found;
  logic                load;
  logic [DATA_WIDTH:0] cur_word;
  int                  idx;

  always_ff @(posedge sys_clk or negedge arst_n) begin
    if (!arst_n) in_ready <= 1'b0;
    else         in_ready <= 1'b1;
  end

  assign s_axis_tready = {CN{in_ready}};

  for (genvar i = 0; i < CN; i++) begin : g_ch
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       wr_commit;
    logic [PW-1:0]       rd_ptr;
    logic                in_frame;
    logic                frame_en;
    logic                dropping;
    logic [15:0]         drop_cnt;
    logic                beat;
    logic                beat_en;
    logic                full;
    logic                do_write;

    assign beat     = s_axis_tvalid[i] && in_ready;
    assign beat_en  = in_frame ? frame_en : i_enable[i];
    assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign do_write = beat && beat_en && !dropping && !full;

    always_ff @(posedge sys_clk) begin
      if (do_write)
        mem[wr_ptr[AW-1:0]] <= {s_axis_tlast[i], s_axis_tdata[DATA_WIDTH*i +: DATA_WIDTH]};
    end

    always_ff @(posedge sys_clk or negedge arst_n) begin
      if (!arst_n) begin
        wr_ptr    <= '0;
        wr_commit <= '0;
        rd_ptr    <= '0;
        in_frame  <= 1'b0;
        frame_en  <= 1'b0;
        dropping  <= 1'b0;
        drop_cnt  <= '0;
      end else begin
        if (pop[i]) rd_ptr <= rd_ptr + PW'(1);
        if (beat) begin
          in_frame <= !s_axis_tlast[i];
          frame_en <= beat_en;
          if (do_write) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (s_axis_tlast[i]) wr_commit <= wr_ptr + PW'(1);
          end else if (beat_en) begin
            // Overflowed frame: swallow the rest, then rewind to the last commit.
            if (s_axis_tlast[i]) begin
              wr_ptr   <= wr_commit;
              dropping <= 1'b0;
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else begin
              dropping <= 1'b1;
            end
          end
        end
      end
    end

    assign avail[i]                    = (wr_commit != rd_ptr);
    assign rd_word[i]                  = mem[rd_ptr[AW-1:0]];
    assign o_drop_count[16*i +: 16]    = drop_cnt;
    assign o_frame_count[16*i +: 16]   = frame_cnt[i];
  end

  assign load     = !m_axis_tvalid || m_axis_tready;
  assign cur_word = rd_word[grant];
  assign pop      = (state == DATA && load) ? (CN'(1) << grant) : '0;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    found      = 1'b0;
    next_grant = last_grant;
    idx        = 0;
    for (int k = 1; k <= CN; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= CN) idx = idx - CN;
      if (!found && avail[CW'(idx)]) begin
        found      = 1'b1;
        next_grant = CW'(idx);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= CW'(CN - 1);
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      for (int c = 0; c < CN; c++) frame_cnt[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) m_axis_tvalid <= 1'b0;
          if (found) begin
            grant <= next_grant;
`ifdef I2S_STREAM_MUX_HDR_EN
            state <= HDR;
`else
            state <= DATA;
`endif
          end
        end
`ifdef I2S_STREAM_MUX_HDR_EN
        HDR: begin
          if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= DATA_WIDTH'(grant);
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= grant;
            state         <= DATA;
          end
        end
`endif
        DATA: begin
          if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= cur_word[DATA_WIDTH-1:0];
            m_axis_tlast  <= cur_word[DATA_WIDTH];
            m_axis_tid    <= grant;
            if (cur_word[DATA_WIDTH]) begin
              frame_cnt[grant] <= frame_cnt[grant] + 16'd1;
              last_grant       <= grant;
              state            <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_stream_mux.sv
`default_nettype none
// Bench for i2s_stream_mux: directed frame table, corner-case sequences and a
// randomized multi-channel run checked against per-channel frame queues.
module tb_i2s_stream_mux;
  localparam int CN    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(CN);
`ifdef I2S_STREAM_MUX_HDR_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic             sys_clk = 1'b0;
  logic             arst_n  = 1'b0;
  logic [CN-1:0]    s_tvalid, s_tlast, s_tready, i_enable;
  logic [DW*CN-1:0] s_tdata;
  logic             m_tvalid, m_tlast, m_tready;
  logic [DW-1:0]    m_tdata;
  logic [CW-1:0]    m_tid;
  logic [16*CN-1:0] frame_count, drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tlast_edge;
  int first_valid_cyc;
  int exp_fc [CN];
  int exp_dc [CN];

  logic [DW-1:0] got_d[$];
  int            got_tid[$];
  bit            got_last[$];
  logic [DW-1:0] rq [CN][$];
  int            rlen [CN][$];

  typedef struct {
    int ch; int len; int base; bit en; bit stall; bit deliver; bit drop;
  } vec_t;
  vec_t vec [8];

  always #4 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  i2s_stream_mux #(.CN(CN), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .arst_n(arst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tready(m_tready),
    .i_enable(i_enable), .o_frame_count(frame_count), .o_drop_count(drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string name);
    for (int c = 0; c < CN; c++) begin
      check({name, "_frame_count"}, 32'(frame_count[16*c +: 16]), exp_fc[c]);
      check({name, "_drop_count"}, 32'(drop_count[16*c +: 16]), exp_dc[c]);
    end
  endtask

  // Enable is toggled on odd beats to show only the first-beat value matters.
  task automatic send_frame(input int ch, input int len, input int base, input bit en);
    for (int b = 0; b < len; b++) begin
      @(negedge sys_clk);
      s_tvalid[ch]          = 1'b1;
      s_tdata[DW*ch +: DW]  = DW'(base + b);
      s_tlast[ch]           = (b == len - 1);
      i_enable[ch]          = (b == 0) ? en : ((b % 2) == 1) ? !en : en;
    end
    tlast_edge = cyc + 1;
    @(negedge sys_clk);
    s_tvalid[ch] = 1'b0;
    s_tlast[ch]  = 1'b0;
    i_enable[ch] = 1'b1;
  endtask

  // Collects one output frame; with stall set, tready runs 1,0,0,1,... over valid cycles.
  task automatic collect(input int budget, input bit stall, input bit expect_none);
    bit            done = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] pd;
    logic          pl;
    logic [CW-1:0] pt;
    int            k = 0;
    int            p = 0;
    got_d.delete(); got_tid.delete(); got_last.delete();
    first_valid_cyc = -1;
    while (!done && k < budget) begin
      @(negedge sys_clk);
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 1);
        check("stall_data", 32'(m_tdata), 32'(pd));
        check("stall_last", 32'(m_tlast), 32'(pl));
        check("stall_tid", 32'(m_tid), 32'(pt));
      end
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      m_tready   = (stall && m_tvalid && ((p % 4) == 1 || (p % 4) == 2)) ? 1'b0 : 1'b1;
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pl = m_tlast; pt = m_tid;
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_tid.push_back(int'(m_tid));
        got_last.push_back(m_tlast);
        if (m_tlast) done = 1'b1;
      end
      if (m_tvalid) p++;
      k++;
    end
    @(negedge sys_clk);
    m_tready = 1'b0;
    if (!expect_none) check("collect_timeout", 32'(done), 1);
  endtask

  task automatic check_frame(input string name, input int ch, input int base, input int len);
    check({name, "_len"}, got_d.size(), len + HB);
    for (int b = 0; b < got_d.size() && b < len + HB; b++) begin
      logic [DW-1:0] e;
      bit            el;
      if (b < HB) begin e = DW'(ch); el = 1'b0; end
      else begin e = DW'(base + b - HB); el = (b == len + HB - 1); end
      check({name, "_data"}, 32'(got_d[b]), 32'(e));
      check({name, "_last"}, 32'(got_last[b]), 32'(el));
      check({name, "_tid"}, got_tid[b], ch);
    end
  endtask

  task automatic run_random(input int total);
    int            started = 0;
    int            pending = 0;
    bit            active [CN];
    bit            fen [CN];
    int            flen [CN];
    int            fpos [CN];
    int            sent [CN];
    int            recv [CN];
    logic [DW-1:0] ob[$];
    int            otid = 0;
    bit            tid_ok = 1'b1;
    bit            any_active;
    for (int c = 0; c < CN; c++) begin
      active[c] = 1'b0; fen[c] = 1'b0; flen[c] = 0; fpos[c] = 0; sent[c] = 0; recv[c] = 0;
    end
    for (int k = 0; k < 4000; k++) begin
      @(negedge sys_clk);
      m_tready = ($urandom_range(0, 3) != 0);
      if (m_tvalid && m_tready) begin
        if (ob.size() == 0) begin otid = int'(m_tid); tid_ok = 1'b1; end
        else if (int'(m_tid) != otid) tid_ok = 1'b0;
        ob.push_back(m_tdata);
        if (m_tlast) begin
          check("rand_tid_stable", 32'(tid_ok), 1);
          check("rand_frame_expected", 32'(rlen[otid].size() > 0), 1);
          if (rlen[otid].size() > 0) begin
            int n;
            n = rlen[otid].pop_front();
            check("rand_len", ob.size(), n + HB);
`ifdef I2S_STREAM_MUX_HDR_EN
            check("rand_hdr", 32'(ob[0]), otid);
`endif
            for (int b = 0; b < n; b++) begin
              logic [DW-1:0] e;
              e = rq[otid].pop_front();
              if (b + HB < ob.size()) check("rand_data", 32'(ob[b + HB]), 32'(e));
            end
            recv[otid] += n;
            exp_fc[otid]++;
            pending--;
          end
          ob.delete();
        end
      end
      any_active = 1'b0;
      for (int c = 0; c < CN; c++) begin
        if (!active[c] && started < total && $urandom_range(0, 2) == 0) begin
          int l;
          bit e;
          l = $urandom_range(1, 5);
          e = ($urandom_range(0, 4) != 0);
          // Never start an enabled frame that could overflow the channel FIFO.
          if (!e || (sent[c] - recv[c] + l <= DEPTH)) begin
            active[c] = 1'b1; fen[c] = e; flen[c] = l; fpos[c] = 0; started++;
            if (e) begin rlen[c].push_back(l); pending++; end
          end
        end
        if (active[c] && $urandom_range(0, 3) != 0) begin
          logic [DW-1:0] d;
          d = DW'($urandom);
          s_tvalid[c]         = 1'b1;
          s_tdata[DW*c +: DW] = d;
          s_tlast[c]          = (fpos[c] == flen[c] - 1);
          i_enable[c]         = (fpos[c] == 0) ? fen[c] : 1'($urandom);
          if (fen[c]) begin rq[c].push_back(d); sent[c]++; end
          fpos[c]++;
          if (fpos[c] == flen[c]) active[c] = 1'b0;
        end else begin
          s_tvalid[c] = 1'b0;
          s_tlast[c]  = 1'b0;
        end
        if (active[c]) any_active = 1'b1;
      end
      if (started == total && pending == 0 && !any_active && ob.size() == 0) break;
    end
    @(negedge sys_clk);
    s_tvalid = '0; s_tlast = '0; i_enable = '1; m_tready = 1'b0;
    check("rand_pending", pending, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{3, 10, 'h30, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[1] = '{3,  3, 'h40, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[2] = '{4,  5, 'h50, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3] = '{4,  2, 'h60, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4] = '{7,  8, 'h70, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[5] = '{6,  9, 'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[6] = '{2,  6, 'h90, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[7] = '{1,  1, 'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < CN; c++) begin exp_fc[c] = 0; exp_dc[c] = 0; end

    s_tvalid = '0; s_tlast = '0; s_tdata = '0; i_enable = '1; m_tready = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tdata", 32'(m_tdata), 0);
    check("rst_m_tlast", 32'(m_tlast), 0);
    check("rst_m_tid", 32'(m_tid), 0);
    check("rst_s_tready", 32'(s_tready), 0);
    check_counters("rst");
    arst_n = 1'b1;
    @(negedge sys_clk);
    check("s_tready_after_rst", 32'(s_tready), 32'hFF);

    // First frame: output appears two edges after the tlast write.
    m_tready = 1'b1;
    send_frame(0, 4, 'h10, 1'b1);
    collect(40, 1'b0, 1'b0);
    check_frame("first", 0, 'h10, 4);
    check("first_latency", first_valid_cyc, tlast_edge + 2);
    exp_fc[0]++;
    check("first_frame_count", 32'(frame_count[15:0]), 1);

    for (int r = 0; r < 8; r++) begin
      send_frame(vec[r].ch, vec[r].len, vec[r].base, vec[r].en);
      collect(vec[r].deliver ? 60 : 15, vec[r].stall, !vec[r].deliver);
      if (vec[r].deliver) begin
        check_frame("table", vec[r].ch, vec[r].base, vec[r].len);
        exp_fc[vec[r].ch]++;
      end else begin
        check("table_no_output", got_d.size(), 0);
      end
      if (vec[r].drop) exp_dc[vec[r].ch]++;
      check("table_frame_count", 32'(frame_count[16*vec[r].ch +: 16]), exp_fc[vec[r].ch]);
      check("table_drop_count", 32'(drop_count[16*vec[r].ch +: 16]), exp_dc[vec[r].ch]);
    end
    check_counters("table");

    // Channel 1 frame parks on the output; 5, 2, 1 commit behind it.
    m_tready = 1'b0;
    send_frame(1, 2, 'hA0, 1'b1);
    send_frame(5, 2, 'hB0, 1'b1);
    send_frame(2, 2, 'hC0, 1'b1);
    send_frame(1, 2, 'hD0, 1'b1);
    collect(40, 1'b0, 1'b0); check_frame("rr0", 1, 'hA0, 2);
    collect(40, 1'b0, 1'b0); check_frame("rr1", 2, 'hC0, 2);
    collect(40, 1'b0, 1'b0); check_frame("rr2", 5, 'hB0, 2);
    collect(40, 1'b0, 1'b0); check_frame("rr3", 1, 'hD0, 2);
    exp_fc[1] += 2; exp_fc[2]++; exp_fc[5]++;
    check_counters("rr");

    run_random(40);
    check_counters("rand");

    // Asynchronous reset with a frame parked on the output and another mid-input.
    m_tready = 1'b0;
    send_frame(2, 3, 'hE0, 1'b1);
    repeat (4) @(negedge sys_clk);
    check("pre_rst_valid", 32'(m_tvalid), 1);
    s_tvalid[3] = 1'b1; s_tdata[DW*3 +: DW] = 8'hF0; s_tlast[3] = 1'b0;
    @(negedge sys_clk);
    s_tdata[DW*3 +: DW] = 8'hF1;
    #2 arst_n = 1'b0;
    #1;
    for (int c = 0; c < CN; c++) begin exp_fc[c] = 0; exp_dc[c] = 0; end
    check("arst_m_tvalid", 32'(m_tvalid), 0);
    check("arst_m_tdata", 32'(m_tdata), 0);
    check("arst_m_tlast", 32'(m_tlast), 0);
    check("arst_m_tid", 32'(m_tid), 0);
    check("arst_s_tready", 32'(s_tready), 0);
    check_counters("arst");
    @(negedge sys_clk);
    s_tvalid = '0; s_tlast = '0;
    arst_n = 1'b1;
    @(negedge sys_clk);
    check("s_tready_after_arst", 32'(s_tready), 32'hFF);
    send_frame(3, 3, 'hC8, 1'b1);
    collect(40, 1'b0, 1'b0);
    check_frame("post_rst", 3, 'hC8, 3);
    exp_fc[3]++;
    check_counters("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_stream_mux.md
# i2s_stream_mux

Single-clock, parametrised successor to the per-channel FIFO plus arbiter stage behind the I2S receivers. Collects CN framed AXI-Stream byte/word streams already in the sys_clk domain and buffers each in a per-channel FIFO with frame commit, so overflowing frames are dropped whole. Forwards complete frames round-robin onto one output stream tagged with the channel index, with per-channel delivered and dropped frame counters. Sits between the I2S receive CDC FIFOs and the packetiser toward the destination FPGA.

## Interface
- CN, 16: number of input channels, 2..32
- DATA_WIDTH, 8: beat width in bits
- DEPTH, 128: per-channel FIFO depth in beats, power of two, ≥ 4
- CW, $clog2(CN): channel index width (derived, not overridden)

- sys_clk  in  1  system clock, 125 MHz
- arst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tvalid  in  CN  per-channel beat valid
- s_axis_tdata  in  DATA_WIDTH*CN  per-channel data, channel i at [DATA_WIDTH*i +: DATA_WIDTH]
- s_axis_tlast  in  CN  end of frame
- s_axis_tready  out  CN  registered, 0 in reset, all-ones from first cycle after reset release
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tlast  out  1  output end of frame
- m_axis_tid  out  CW  source channel of current beat
- m_axis_tready  in  1  downstream ready
- i_enable  in  CN  channel enable, sampled at first beat of each input frame
- o_frame_count  out  16*CN  frames delivered per channel, wrapping
- o_drop_count  out  16*CN  frames dropped on overflow per channel, saturating at 0xFFFF

## Operation
- Per-channel FIFO: DATA_WIDTH+1 bits wide (data, last); pointers wr_ptr, wr_commit, rd_ptr, each log2(DEPTH)+1 bits, compare with wrap bit.
- Full when wr_ptr − rd_ptr == DEPTH. Frame available when wr_commit ≠ rd_ptr.
- Input beat with tvalid: if frame enabled, not dropping, and not full, write at wr_ptr and increment.
- Tlast written: wr_commit <= wr_ptr+1.
- Full on a beat: set drop flag, discard the beat and the remaining beats of the frame. At its tlast, rewind wr_ptr to wr_commit, increment o_drop_count, clear the flag.
- Frame started with i_enable[i]=0: all beats discarded, no counter change. Committed frames still drain after disable.
- Arbiter FSM states: IDLE, HDR (only with macro), DATA.
  - IDLE: grant the first channel with an available frame searching from last_grant+1 modulo CN. Go to DATA (or HDR). No request: stay in IDLE.
  - DATA: pop one beat per output load. On loading the beat with last=1, increment o_frame_count[grant], record last_grant, go to IDLE.
- Output is a single register stage. It loads when !m_axis_tvalid || m_axis_tready. m_axis_tdata, tlast and tid hold while tvalid && !tready.
- Simultaneous write and read on the same FIFO is legal. Full is evaluated on pre-update pointers, so a pop in the same cycle does not rescue a beat.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, s_axis_tready=0, all counters 0, FSM IDLE, last_grant=CN−1, all pointers 0.
- Reset mid-frame: all buffered data lost. The first post-reset input beat is treated as a frame start.
- Commit to output: tlast written in cycle t, grant in t+1, first beat on m_axis_tvalid in t+2.
- Throughput: one beat per cycle within a frame. Frames are separated by one IDLE bubble, plus the HDR beat when enabled.
- Counter updates are visible the cycle after the triggering event.

## Configuration
- I2S_STREAM_MUX_HDR_EN defined: HDR state emits one header beat before each frame.
  - Header tdata = zero-extended channel index, tlast=0, tid=grant.
  - Frame length on output is N+1 beats.
- Undefined: HDR state absent; output frames are exactly the input frames.

## Test plan
- Reset release, channel 0 sends a 4-beat frame 0x10..0x13 with m_axis_tready=1 -> output 0x10..0x13 with tid=0, tlast on 0x13, first output two cycles after input tlast, o_frame_count[0]=1.
- Channels 1, 2 and 5 each hold a committed frame, arbiter in IDLE with last_grant=1 -> delivery order 2, 5, 1.
- DEPTH=8, channel 3 sends a 10-beat frame with tready=0 -> frame dropped, o_drop_count[3]=1. A following 3-beat frame after drain is delivered intact.
- m_axis_tready toggles 1-0-0-1 mid-frame -> no beat lost or duplicated, tdata/tlast/tid stable while stalled.
- i_enable[4]=0 at frame start, deasserted-then-reasserted mid-frame -> whole frame discarded, both counters unchanged. The next frame with enable=1 is delivered.
- With I2S_STREAM_MUX_HDR_EN, 2-beat frame on channel 7 -> output 0x07, d0, d1 with tlast on d1. arst_n pulsed mid-frame -> outputs return to reset values immediately.
